trap_ctrl: RTL

Machine-mode trap controller for the RV64 core; consumes the level `timer_int_i` from the timer and the retire stream from the commit stage. Holds the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) and decides at each commit boundary whether to take a timer interrupt, an ecall, or an mret. It then issues a one-cycle pipeline redirect to the trap vector or to mepc.

---
 rtl/trap_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap CSRs and commit-boundary redirect FSM
module trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_int_i,
  input  logic        commit_valid_i,
  input  logic [63:0] commit_pc_i,
  input  logic [63:0] commit_next_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  output logic        int_pending_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [63:0] CAUSE_MTI    = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL  = 64'd11;

  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_next;

  logic        mstatus_mie, mstatus_mpie, mie_mtie;
  logic [63:0] mtvec, mepc, mcause;

  logic        decide;
  logic        take_int, take_ecall, take_mret, take_trap, any_event;
  logic [63:0] trap_vector, target;

  assign int_pending_o = timer_int_i & mie_mtie & mstatus_mie;
  assign trap_vector   = {mtvec[63:2], 2'b00};

  // Priority: interrupt over ecall over mret; nothing is decided while flushing.
  assign decide     = (state == IDLE) && commit_valid_i;
  assign take_int   = decide && int_pending_o;
  assign take_ecall = decide && !int_pending_o && ecall_i;
  assign take_mret  = decide && !int_pending_o && !ecall_i && mret_i;
  assign take_trap  = take_int || take_ecall;
  assign any_event  = take_trap || take_mret;
  assign target     = take_mret ? mepc : trap_vector;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_event) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    redirect_o = (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         redirect_pc_o <= '0;
    else if (any_event) redirect_pc_o <= target;
  end

  // Trap/mret updates win over a same-cycle software write to the same CSR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else begin
      if (take_trap) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        mcause       <= take_int ? CAUSE_MTI : CAUSE_ECALL;
        mepc         <= (take_ecall || ecall_i || mret_i) ?
                        {commit_pc_i[63:2], 2'b00} : {commit_next_pc_i[63:2], 2'b00};
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
      if (csr_we_i) begin
        case (csr_waddr_i)
          ADDR_MSTATUS: if (!any_event) begin
            mstatus_mie  <= csr_wdata_i[3];
            mstatus_mpie <= csr_wdata_i[7];
          end
          ADDR_MIE:    mie_mtie <= csr_wdata_i[7];
          ADDR_MTVEC:  mtvec <= csr_wdata_i;
          ADDR_MEPC:   if (!take_trap) mepc <= {csr_wdata_i[63:2], 2'b00};
          ADDR_MCAUSE: if (!take_trap) mcause <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      ADDR_MSTATUS: csr_rdata_o = {51'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:     csr_rdata_o = {56'b0, mie_mtie, 7'b0};
      ADDR_MTVEC:   csr_rdata_o = mtvec;
      ADDR_MEPC:    csr_rdata_o = mepc;
      ADDR_MCAUSE:  csr_rdata_o = mcause;
      ADDR_MIP:     csr_rdata_o = {56'b0, timer_int_i, 7'b0};
      default:      csr_rdata_o = '0;
    endcase
  end

endmodule
